// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and sequences one per cycle into the ALU; result registered 2 cycles after accept.
// Stalls the FIFO head while the result slot is full; cmd_ready = !full. ALU_SEQ_CHAIN_EN enables result chaining into A.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic        cmd_chain,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_x,
    input  logic [7:0]  alu_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [2:0]  res_op,
    output logic        res_err,
    output logic        busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, STALL} state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem_a  [FIFO_DEPTH];
    logic [7:0]      mem_b  [FIFO_DEPTH];
    logic [2:0]      mem_op [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head_idx;
    logic            push;
    logic            capture;
    logic            load_head;
    logic            slot_free;
    logic [7:0]      alu_a_next;

`ifdef ALU_SEQ_CHAIN_EN
    logic            mem_chain [FIFO_DEPTH];
    logic [7:0]      chain_reg;
`else
    logic            unused_chain;
    assign unused_chain = cmd_chain;
`endif

    assign cmd_ready = !rst && (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign slot_free = !res_valid || res_ready;
    assign busy      = (count != '0) || res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remaining entries are judged from the registered count, so a push
    // landing in the same cycle as the last pop is picked up via IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) state_next = EXEC;
            end
            EXEC, STALL: begin
                if (slot_free) state_next = (count > CW'(1)) ? EXEC : IDLE;
                else           state_next = STALL;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture   = 1'b0;
        load_head = 1'b0;
        head_idx  = rd_ptr;
        case (state)
            IDLE: begin
                load_head = (count != '0);
            end
            EXEC, STALL: begin
                capture   = slot_free;
                load_head = slot_free && (count > CW'(1));
                head_idx  = rd_ptr + PW'(1);
            end
            default: ;
        endcase
        alu_a_next = mem_a[head_idx];
`ifdef ALU_SEQ_CHAIN_EN
        // A capture in this cycle updates the chain register at the same edge,
        // so the freshest value is alu_x itself.
        if (mem_chain[head_idx]) alu_a_next = (state == IDLE) ? chain_reg : alu_x;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]     <= cmd_a;
            mem_b[wr_ptr]     <= cmd_b;
            mem_op[wr_ptr]    <= cmd_op;
`ifdef ALU_SEQ_CHAIN_EN
            mem_chain[wr_ptr] <= cmd_chain;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_reg <= '0;
`endif
        end else begin
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (capture) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(capture);

            if (load_head) begin
                alu_a  <= alu_a_next;
                alu_b  <= mem_b[head_idx];
                alu_op <= mem_op[head_idx];
            end else if (capture) begin
                alu_a  <= '0;
                alu_b  <= '0;
                alu_op <= '0;
            end

            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= {alu_y, alu_x};
                res_op    <= alu_op;
                res_err   <= (alu_op >= 3'd5);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
`ifdef ALU_SEQ_CHAIN_EN
            if (capture) chain_reg <= alu_x;
`endif
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic        cmd_chain;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        res_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_x(alu_x), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU: add/sub give a 9-bit result (carry/borrow in y[0]); shifts move by one.
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [15:0] alu_res;
    always_comb begin
        sum9    = {1'b0, alu_a} + {1'b0, alu_b};
        diff9   = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res = 16'h0000;
        case (alu_op)
            3'd0: alu_res = {7'b0, sum9};
            3'd1: alu_res = {7'b0, diff9};
            3'd2: alu_res = 16'(alu_a) * 16'(alu_b);
            3'd3: alu_res = {7'b0, alu_a, 1'b0};
            3'd4: alu_res = {9'b0, alu_a[7:1]};
            default: alu_res = 16'h0000;
        endcase
    end
    assign alu_x = alu_res[7:0];
    assign alu_y = alu_res[15:8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ch);
        logic ok;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain(input string tag);
        res_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            if (res_valid) check(tag, 32'({res_err, res_op, res_data}), 32'(exp_q.pop_front()));
            tick();
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0]  va [5];
    logic [7:0]  vb [5];
    logic [2:0]  vo [5];
    logic [15:0] vr [5];
    logic        acc5;
    int          seen;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_chain = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_data", 32'(res_data), 0);

        // Latency into an empty block
        res_ready = 1'b1;
        cmd_a = 8'h0F; cmd_b = 8'h01; cmd_op = 3'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_n_alu_a", 32'(alu_a), 0);
        check("lat_n_vld", 32'(res_valid), 0);
        tick();
        check("lat_n1_alu_a", 32'(alu_a), 32'h0F);
        check("lat_n1_alu_b", 32'(alu_b), 32'h01);
        check("lat_n1_vld", 32'(res_valid), 0);
        tick();
        check("lat_n2_vld", 32'(res_valid), 1);
        check("lat_n2_res", 32'({res_err, res_op, res_data}), 32'h00010);
        check("lat_n2_busy", 32'(busy), 1);
        tick();
        check("lat_n3_vld", 32'(res_valid), 0);
        check("lat_n3_busy", 32'(busy), 0);

        // Fill to full behind an occupied result slot
        res_ready = 1'b0;
        push(8'h10, 8'h20, 3'd0, 1'b0);
        exp_q.push_back({1'b0, 3'd0, 16'h0030});
        for (int i = 0; i < 10 && !res_valid; i++) tick();
        check("pre_fill_vld", 32'(res_valid), 1);
        va = '{8'h05, 8'h03, 8'h10, 8'hC3, 8'hFF};
        vb = '{8'h03, 8'h05, 8'h10, 8'h00, 8'h01};
        vo = '{3'd1,  3'd1,  3'd2,  3'd3,  3'd0};
        vr = '{16'h0002, 16'h01FE, 16'h0100, 16'h0186, 16'h0100};
        for (int k = 0; k < 4; k++) begin
            cmd_a = va[k]; cmd_b = vb[k]; cmd_op = vo[k]; cmd_chain = 1'b0; cmd_valid = 1'b1;
            check("fill_ready", 32'(cmd_ready), 1);
            tick();
        end
        cmd_a = va[4]; cmd_b = vb[4]; cmd_op = vo[4];
        for (int k = 0; k < 3; k++) begin
            check("full_ready", 32'(cmd_ready), 0);
            check("stall_alu_a", 32'(alu_a), 32'h05);
            check("stall_alu_op", 32'(alu_op), 1);
            tick();
        end
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, vo[k], vr[k]});
        res_ready = 1'b1;
        acc5 = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            logic acc;
            if (res_valid) check("order", 32'({res_err, res_op, res_data}), 32'(exp_q.pop_front()));
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                cmd_valid = 1'b0;
                acc5 = 1'b1;
            end
        end
        check("order_left", 32'(exp_q.size()), 0);
        check("fifth_accepted", 32'(acc5), 1);
        cmd_valid = 1'b0;

        // Multiply and shift-right
        res_ready = 1'b0;
        push(8'hFF, 8'hFF, 3'd2, 1'b0);
        push(8'h81, 8'h00, 3'd4, 1'b0);
        exp_q.push_back({1'b0, 3'd2, 16'hFE01});
        exp_q.push_back({1'b0, 3'd4, 16'h0040});
        drain("mul_shr");
        check("idle_busy", 32'(busy), 0);

        // Invalid op
        res_ready = 1'b0;
        push(8'h12, 8'h34, 3'd6, 1'b0);
        exp_q.push_back({1'b1, 3'd6, 16'h0000});
        drain("invalid_op");

        // Chain
        res_ready = 1'b0;
        push(8'h03, 8'h04, 3'd0, 1'b0);
        push(8'hAA, 8'h01, 3'd0, 1'b1);
        exp_q.push_back({1'b0, 3'd0, 16'h0007});
`ifdef ALU_SEQ_CHAIN_EN
        exp_q.push_back({1'b0, 3'd0, 16'h0008});
`else
        exp_q.push_back({1'b0, 3'd0, 16'h00AB});
`endif
        drain("chain");

        // Reset mid-operation
        res_ready = 1'b0;
        push(8'h09, 8'h02, 3'd1, 1'b0);
        push(8'h01, 8'h01, 3'd0, 1'b0);
        push(8'h02, 8'h02, 3'd2, 1'b0);
        push(8'h04, 8'h04, 3'd3, 1'b0);
        check("pre_rst_vld", 32'(res_valid), 1);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", 32'(cmd_ready), 0);
        check("mid_rst_vld", 32'(res_valid), 0);
        check("mid_rst_data", 32'(res_data), 0);
        check("mid_rst_op", 32'(res_op), 0);
        check("mid_rst_err", 32'(res_err), 0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) seen++;
        end
        check("post_rst_results", 32'(seen), 0);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
